// File: rtl/vga_blit_controller_if.sv
// CPU-side access bus of the VGA blit controller: request/grant handshake plus read return.
interface vga_blit_controller_if;
    logic        cpu_req;
    logic        cpu_we;
    logic        cpu_byte_op;
    logic [14:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic        cpu_grant;
    logic        cpu_rvalid;
    logic [15:0] cpu_rdata;

    modport master (
        output cpu_req, cpu_we, cpu_byte_op, cpu_addr, cpu_wdata,
        input  cpu_grant, cpu_rvalid, cpu_rdata
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_byte_op, cpu_addr, cpu_wdata,
        output cpu_grant, cpu_rvalid, cpu_rdata
    );
endinterface

// File: rtl/vga_blit_controller.sv
// Arbitrates the single vga_memory_system io port between CPU accesses and a fill/copy blitter,
// with CPU priority bounded by a starvation counter.
module vga_blit_controller #(
    parameter int READ_LATENCY = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 main_clk,
    input  logic                 reset,
    vga_blit_controller_if.slave cpu,
    input  logic                 cmd_start,
    input  logic [1:0]           cmd_op,
    input  logic [13:0]          cmd_src,
    input  logic [13:0]          cmd_dst,
    input  logic [14:0]          cmd_len,
    input  logic [15:0]          cmd_fill,
    output logic                 busy,
    output logic                 done,
    output logic                 cmd_rejected,
    output logic                 io_do_write,
    output logic                 io_do_byte_op,
    output logic [14:0]          io_addr,
    output logic [15:0]          io_write_data,
    input  logic [15:0]          io_read_data
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int WW = (READ_LATENCY > 2) ? $clog2(READ_LATENCY - 1) : 1;

    typedef enum logic [2:0] {IDLE, FILL, CP_RD, CP_WAIT, CP_WR, DONE} state_t;

    state_t                  state;
    logic [SW-1:0]           starve_cnt;
    logic [WW-1:0]           wait_cnt;
    logic [READ_LATENCY-1:0] cpu_tag_p;
    logic                    first_wr;

    logic [13:0] src;
    logic [13:0] dst;
    logic [14:0] len;
    logic [15:0] fill;
    logic        desc;
    logic [15:0] hold;
    logic [14:0] last_addr;

    logic        blit_want;
    logic        cpu_win;
    logic        blit_go;
    logic        accept;
    logic        last_word;
    logic [13:0] src_step;
    logic [13:0] dst_step;
    logic [15:0] wr_word;

    assign blit_want = (state == FILL) || (state == CP_RD) || (state == CP_WR);
    assign cpu_win   = !reset && cpu.cpu_req &&
                       (!blit_want || (starve_cnt < SW'(STARVE_LIMIT)));
    assign blit_go   = !reset && blit_want && !cpu_win;
    assign accept    = (state == IDLE) && cmd_start && (cmd_op != 2'd3);
    assign last_word = (len == 15'd1);
    assign src_step  = desc ? src - 14'd1 : src + 14'd1;
    assign dst_step  = desc ? dst - 14'd1 : dst + 14'd1;
    // Read data arrives in the first CP_WR cycle; later (ungranted) cycles replay it from hold.
    assign wr_word   = first_wr ? io_read_data : hold;

    assign cpu.cpu_grant  = cpu_win;
    assign cpu.cpu_rvalid = cpu_tag_p[READ_LATENCY-1];
    assign cpu.cpu_rdata  = io_read_data;

    always_comb begin
        io_do_write   = 1'b0;
        io_do_byte_op = 1'b0;
        io_addr       = last_addr;
        io_write_data = cpu.cpu_wdata;
        if (cpu_win) begin
            io_do_write   = cpu.cpu_we;
            io_do_byte_op = cpu.cpu_byte_op;
            io_addr       = cpu.cpu_addr;
            io_write_data = cpu.cpu_wdata;
        end else if (blit_go) begin
            case (state)
                FILL: begin
                    io_do_write   = 1'b1;
                    io_addr       = {dst, 1'b0};
                    io_write_data = fill;
                end
                CP_RD: begin
                    io_addr = {src, 1'b0};
                end
                CP_WR: begin
                    io_do_write   = 1'b1;
                    io_addr       = {dst, 1'b0};
                    io_write_data = wr_word;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge main_clk) begin
        if (reset) begin
            state        <= IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            cmd_rejected <= 1'b0;
            starve_cnt   <= '0;
            cpu_tag_p    <= '0;
            first_wr     <= 1'b0;
        end else begin
            done         <= 1'b0;
            cmd_rejected <= cmd_start && ((state != IDLE) || (cmd_op == 2'd3));
            cpu_tag_p    <= {cpu_tag_p[READ_LATENCY-2:0], cpu_win & ~cpu.cpu_we};
            starve_cnt   <= (blit_want && cpu_win) ? starve_cnt + SW'(1) : '0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (cmd_len == 15'd0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= (cmd_op == 2'd0) ? FILL : CP_RD;
                            busy  <= 1'b1;
                        end
                    end
                end
                FILL: begin
                    if (blit_go && last_word) begin
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                CP_RD: begin
                    if (blit_go) begin
                        state    <= CP_WAIT;
                        wait_cnt <= WW'(READ_LATENCY - 2);
                    end
                end
                CP_WAIT: begin
                    if (wait_cnt == '0) begin
                        state    <= CP_WR;
                        first_wr <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt - WW'(1);
                    end
                end
                CP_WR: begin
                    first_wr <= 1'b0;
                    if (blit_go) begin
                        if (last_word) begin
                            state <= DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state <= CP_RD;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Command operands and address pointers carry no reset; the FSM state qualifies them.
    always_ff @(posedge main_clk) begin
        last_addr <= io_addr;
        if (accept) begin
            src  <= cmd_src;
            dst  <= cmd_dst;
            len  <= cmd_len;
            fill <= cmd_fill;
            desc <= (cmd_op == 2'd2);
        end else if (blit_go && (state == FILL)) begin
            dst <= dst_step;
            len <= len - 15'd1;
        end else if (blit_go && (state == CP_WR)) begin
            src <= src_step;
            dst <= dst_step;
            len <= len - 15'd1;
        end
        if ((state == CP_WR) && first_wr) hold <= io_read_data;
    end

endmodule
